// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
// Shared constants for the PS/2 key encoder:
//   - selector codes driven to the cell-colour selector (0 = none, 1..9 = cell,
//     10/11/12 = R/G/B colour commands)
//   - PS/2 set-2 scancodes for the break/extended prefixes and the mapped keys
//   - frame receiver FSM state encoding
//   - sc_to_code(): make scancode -> selector code (CODE_NONE when unmapped)
// -----------------------------------------------------------------------------
package kbd_pkg;

  localparam logic [3:0] CODE_NONE  = 4'd0;
  localparam logic [3:0] CODE_RED   = 4'd10;
  localparam logic [3:0] CODE_GREEN = 4'd11;
  localparam logic [3:0] CODE_BLUE  = 4'd12;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_KEY1  = 8'h16;
  localparam logic [7:0] SC_KEY2  = 8'h1E;
  localparam logic [7:0] SC_KEY3  = 8'h26;
  localparam logic [7:0] SC_KEY4  = 8'h25;
  localparam logic [7:0] SC_KEY5  = 8'h2E;
  localparam logic [7:0] SC_KEY6  = 8'h36;
  localparam logic [7:0] SC_KEY7  = 8'h3D;
  localparam logic [7:0] SC_KEY8  = 8'h3E;
  localparam logic [7:0] SC_KEY9  = 8'h46;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_B     = 8'h32;

  // Frame receiver states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RX   = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [3:0] sc_to_code(input logic [7:0] sc);
    logic [3:0] code;
    case (sc)
      SC_KEY1: code = 4'd1;
      SC_KEY2: code = 4'd2;
      SC_KEY3: code = 4'd3;
      SC_KEY4: code = 4'd4;
      SC_KEY5: code = 4'd5;
      SC_KEY6: code = 4'd6;
      SC_KEY7: code = 4'd7;
      SC_KEY8: code = 4'd8;
      SC_KEY9: code = 4'd9;
      SC_R:    code = CODE_RED;
      SC_G:    code = CODE_GREEN;
      SC_B:    code = CODE_BLUE;
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// -----------------------------------------------------------------------------
// ps2_key_encoder_if
// Bundles the raw PS/2 pins and the selector-side outputs of the encoder.
//   ps2_clk, ps2_data : raw PS/2 pins (asynchronous to the system clock)
//   bin               : 4-bit selector code
//   key_valid         : one-cycle pulse when bin is (re)loaded by a make code
//   frame_err         : one-cycle pulse on a framing error or timeout
// Modports:
//   master : keyboard/environment side (drives pins, observes outputs)
//   slave  : encoder side (reads pins, drives outputs)
// -----------------------------------------------------------------------------
interface ps2_key_encoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] bin;
  logic       key_valid;
  logic       frame_err;

  modport master (output ps2_clk, output ps2_data,
                  input bin, input key_valid, input frame_err);
  modport slave  (input ps2_clk, input ps2_data,
                  output bin, output key_valid, output frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// -----------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 frame receiver: synchronizes the raw pins, detects ps2_clk falling
// edges, shifts in start/8 data (LSB first)/parity/stop, and guards each frame
// with a watchdog.
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   ps2_clk_i         : raw PS/2 clock pin
//   ps2_data_i        : raw PS/2 data pin
//   byte_o            : last received data byte (valid with byte_valid_o)
//   byte_valid_o      : one-cycle pulse, good frame received
//   err_o             : one-cycle pulse, bad start, timeout, bad stop/parity
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
// -----------------------------------------------------------------------------
module ps2_rx_frame
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  // Synchronizer chains, reset to the idle-high line level
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign clk_sync_d[gi]  = ps2_clk_i;
        assign data_sync_d[gi] = ps2_data_i;
      end else begin : g_tail
        assign clk_sync_d[gi]  = clk_sync_q[gi-1];
        assign data_sync_d[gi] = data_sync_q[gi-1];
      end
    end
  endgenerate

  logic            clk_prev_q;
  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            stop_q, stop_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_valid_q, byte_valid_d;
  logic            err_q, err_d;
  logic            ps2_fall, ps2_bit, frame_ok;

  assign ps2_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign ps2_bit  = data_sync_q[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  // Odd parity: data bits plus parity bit must contain an odd number of ones
  assign frame_ok = stop_q & (^{par_q, data_q});
`else
  assign frame_ok = stop_q;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    stop_d       = stop_q;
    wd_d         = wd_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    err_d        = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (ps2_fall) begin
          if (!ps2_bit) begin
            state_d = ST_RX;
            cnt_d   = 4'd0;
          end else begin
            err_d = 1'b1;  // start bit must be low
          end
        end
      end
      ST_RX: begin
        if (ps2_fall) begin
          wd_d = '0;
          if (cnt_q < 4'd8) data_d = {ps2_bit, data_q[7:1]};
`ifdef PS2_PARITY_CHECK_EN
          if (cnt_q == 4'd8) par_d = ps2_bit;
`endif
          if (cnt_q == 4'd9) begin
            stop_d  = ps2_bit;
            state_d = ST_DONE;
          end
          cnt_d = cnt_q + 4'd1;
        end else if (wd_q == WD_LAST) begin
          // Keyboard stalled mid-frame: drop the partial byte
          state_d = ST_IDLE;
          err_d   = 1'b1;
          cnt_d   = 4'd0;
          data_d  = '0;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        if (frame_ok) begin
          byte_d       = data_q;
          byte_valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      data_q       <= '0;
      stop_q       <= 1'b0;
      wd_q         <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      stop_q       <= stop_d;
      wd_q         <= wd_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= par_d;
`endif
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// -----------------------------------------------------------------------------
// ps2_key_encoder
// Converts PS/2 keyboard scancodes into the 4-bit selector code consumed by
// the cell-colour selector. Keys 1..9 -> 1..9, R/G/B -> 10/11/12. The code is
// held while the key is down and cleared when that same key is released.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ps2        : ps2_key_encoder_if.slave (ps2_clk, ps2_data in;
//                bin, key_valid, frame_err out)
// Build option: define PS2_PARITY_CHECK_EN to enable odd-parity checking.
// -----------------------------------------------------------------------------
module ps2_key_encoder
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input logic             clk,
  input logic             rst_n,
  ps2_key_encoder_if.slave ps2
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic [3:0] rx_code;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_i   (ps2.ps2_clk),
    .ps2_data_i  (ps2.ps2_data),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .err_o       (rx_err)
  );

  assign rx_code = sc_to_code(rx_byte);

  logic [3:0] bin_q, bin_d;
  logic       kv_q, kv_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;

  always_comb begin
    bin_d = bin_q;
    kv_d  = 1'b0;
    brk_d = brk_q;
    ext_d = ext_q;
    if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys are not part of the map; swallow make and break alike
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        // Only releasing the key that owns bin clears it; older keys are ignored
        if (rx_code == bin_q) bin_d = CODE_NONE;
        brk_d = 1'b0;
      end else if (rx_code != CODE_NONE) begin
        bin_d = rx_code;
        kv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= CODE_NONE;
      kv_q  <= 1'b0;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      kv_q  <= kv_d;
      brk_q <= brk_d;
      ext_q <= ext_d;
    end
  end

  assign ps2.bin       = bin_q;
  assign ps2.key_valid = kv_q;
  assign ps2.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_encoder
// Drives PS/2 frames into ps2_key_encoder and compares bin, key_valid pulses,
// frame_err pulses and make-code latency against a scancode-level model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_encoder;

  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int HALF = 10;   // clk cycles per PS/2 clock half period

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ps2_key_encoder_if ifc();

  ps2_key_encoder #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ps2  (ifc)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int kv_cnt = 0;
  int err_cnt = 0;
  int kv_cyc = 0;
  int stop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.key_valid === 1'b1) begin
        kv_cnt <= kv_cnt + 1;
        kv_cyc <= cyc;
      end
      if (ifc.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model: keyboard as seen by the selector -------
  int  key_code [int];
  bit  m_brk, m_ext;
  int  m_bin;

  function automatic int code_of(input int sc);
    return key_code.exists(sc) ? key_code[sc] : 0;
  endfunction

  // Apply one received scancode; returns 1 if a make pulse is expected
  function automatic int model_byte(input int sc);
    int c;
    c = code_of(sc);
    if (sc == 'hE0) begin
      m_ext = 1;
      return 0;
    end
    if (sc == 'hF0) begin
      m_brk = 1;
      return 0;
    end
    if (m_ext) begin
      m_ext = 0;
      m_brk = 0;
      return 0;
    end
    if (m_brk) begin
      m_brk = 0;
      if (c != 0 && c == m_bin) m_bin = 0;
      return 0;
    end
    if (c != 0) begin
      m_bin = c;
      return 1;
    end
    return 0;
  endfunction

  // ---------------- PS/2 pin driver ----------------------------------------
  task automatic ps2_bit(input bit v);
    ifc.ps2_data = v;
    repeat (HALF) @(negedge clk);
    ifc.ps2_clk = 1'b0;
    stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ifc.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_v);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip_par);
    ps2_bit(stop_v);
    ifc.ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    ifc.ps2_data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit flip, input bit stop_v, input string tag);
    int kv0, er0, exp_kv, exp_err;
    kv0 = kv_cnt;
    er0 = err_cnt;
    send_frame(b, flip, stop_v);
    exp_err = 0;
    exp_kv  = 0;
    if (!stop_v) exp_err = 1;
`ifdef PS2_PARITY_CHECK_EN
    if (stop_v && flip) exp_err = 1;
`endif
    if (exp_err == 0) exp_kv = model_byte(int'(b));
    $display("frame %s byte=%02h bin=%0d exp_bin=%0d kv=%0d err=%0d",
             tag, b, ifc.bin, m_bin, kv_cnt - kv0, err_cnt - er0);
    chk({tag, "_bin"}, {28'd0, ifc.bin}, m_bin);
    chk({tag, "_kv"}, kv_cnt - kv0, exp_kv);
    chk({tag, "_err"}, err_cnt - er0, exp_err);
    if (exp_kv != 0) chk({tag, "_lat"}, kv_cyc - stop_cyc, SYNC + 3);
  endtask

  logic [7:0] pool [0:17];

  initial begin
    int er0, kv0;
    key_code['h16] = 1;  key_code['h1E] = 2;  key_code['h26] = 3;
    key_code['h25] = 4;  key_code['h2E] = 5;  key_code['h36] = 6;
    key_code['h3D] = 7;  key_code['h3E] = 8;  key_code['h46] = 9;
    key_code['h2D] = 10; key_code['h34] = 11; key_code['h32] = 12;
    pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
             8'h2D, 8'h34, 8'h32, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h5A};
    m_bin = 0; m_brk = 0; m_ext = 0;

    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    $display("reset bin=%0d kv=%0d err=%0d", ifc.bin, ifc.key_valid, ifc.frame_err);
    chk("rst_bin", {28'd0, ifc.bin}, 0);
    chk("rst_kv", {31'd0, ifc.key_valid}, 0);
    chk("rst_err", {31'd0, ifc.frame_err}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic make and typematic repeat
    do_frame(8'h16, 0, 1, "k1");
    do_frame(8'h16, 0, 1, "k1_rep");

    // Press and release G
    do_frame(8'h34, 0, 1, "g");
    do_frame(8'hF0, 0, 1, "g_brk");
    do_frame(8'h34, 0, 1, "g_rel");

    // Overlapping keys, release of the older one
    do_frame(8'h1E, 0, 1, "k2");
    do_frame(8'h26, 0, 1, "k3");
    do_frame(8'hF0, 0, 1, "k2_brk");
    do_frame(8'h1E, 0, 1, "k2_rel");

    // Extended prefix and unmapped make
    do_frame(8'h2E, 0, 1, "k5");
    do_frame(8'hE0, 0, 1, "ext");
    do_frame(8'h16, 0, 1, "ext_16");
    do_frame(8'h1C, 0, 1, "unmapped");
    do_frame(8'h3D, 0, 1, "k7_after_ext");

    // Watchdog timeout mid-frame
    er0 = err_cnt;
    kv0 = kv_cnt;
    send_partial(4);
    repeat (TMO + 40) @(negedge clk);
    $display("timeout bin=%0d err=%0d", ifc.bin, err_cnt - er0);
    chk("tmo_err", err_cnt - er0, 1);
    chk("tmo_kv", kv_cnt - kv0, 0);
    chk("tmo_bin", {28'd0, ifc.bin}, m_bin);
    do_frame(8'h2D, 0, 1, "r_after_tmo");

    // Flipped parity bit
    do_frame(8'h32, 1, 1, "b_badpar");

    // Stop bit low
    do_frame(8'h16, 0, 0, "badstop");

    // Start bit high
    er0 = err_cnt;
    kv0 = kv_cnt;
    ifc.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ifc.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ifc.ps2_clk = 1'b1;
    repeat (HALF + 10) @(negedge clk);
    $display("badstart err=%0d", err_cnt - er0);
    chk("badstart_err", err_cnt - er0, 1);
    chk("badstart_kv", kv_cnt - kv0, 0);

    // Randomized scancode stream
    for (int n = 0; n < 30; n++) begin
      do_frame(pool[$urandom_range(0, 17)], 0, 1, "rnd");
    end

    // Reset mid-frame with a pending break flag
    do_frame(8'h36, 0, 1, "k6");
    do_frame(8'hF0, 0, 1, "pre_rst_brk");
    send_partial(2);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("midreset bin=%0d kv=%0d err=%0d", ifc.bin, ifc.key_valid, ifc.frame_err);
    chk("mrst_bin", {28'd0, ifc.bin}, 0);
    chk("mrst_kv", {31'd0, ifc.key_valid}, 0);
    chk("mrst_err", {31'd0, ifc.frame_err}, 0);
    m_bin = 0; m_brk = 0; m_ext = 0;
    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_frame(8'h46, 0, 1, "k9_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_encoder.md
Name: ps2_key_encoder

Overview:
- Upstream stage of the cell-colour selector. Receives PS/2 keyboard frames and converts key presses into the 4-bit selector code that stage samples every clock.
- Code map: keys 1..9 produce codes 1..9 (select a cell). Keys R/G/B produce codes 10/11/12 (colour commands).
- Output is held while the key is down and returns to 0 on release.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles with no ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop stages on ps2_clk and ps2_data before edge detection (minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk.
- bin  out  4  selector code: 0 = none, 1..9 = cell, 10 = R, 11 = G, 12 = B.
- key_valid  out  1  one-cycle pulse when bin is (re)loaded by a make code.
- frame_err  out  1  one-cycle pulse on a framing error or timeout.

Behaviour:
- Reset: async on rst_n low. bin=0, key_valid=0, frame_err=0, state=IDLE, bit count=0, shift register=0, brk/ext flags=0, synchronizers=1.
- Sync and edge detect: ps2_clk is sampled through SYNC_STAGES flops. A falling edge is prev=1, cur=0 after sync. ps2_data is sampled on the same cycle from its own synchronizer.
- Frame FSM:
  - IDLE: on a falling edge, data=0 goes to RX with count=0. data=1 (bad start) stays in IDLE and pulses frame_err.
  - RX: each falling edge shifts data in LSB first. Count 0..7 = data bits, 8 = parity, 9 = stop. The stop-bit edge goes to DONE.
  - RX timeout: a watchdog counter clears on every edge. Reaching TIMEOUT_CYCLES-1 goes to IDLE, pulses frame_err, and discards the partial byte.
  - DONE (one cycle): stop=0 gives frame_err and no decode. Otherwise the byte goes to the decoder. Always returns to IDLE.
- Decoder, applied in the DONE cycle; bin and key_valid are registered and visible the next cycle:
  - 0xE0: set ext. 0xF0: set brk. No output change for either.
  - ext=1 byte: ignored; clears ext and brk.
  - brk=1 byte: if it maps to a code equal to the current bin, then bin<=0. Always clears brk. No key_valid.
  - Mapped make byte: bin<=code, key_valid=1. Typematic repeats of the same make re-pulse key_valid with bin unchanged.
  - Make map: 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9, 0x2D→10, 0x34→11, 0x32→12.
  - Unmapped make: bin unchanged, no pulse.
- Overlap: a new key pressed while another is held replaces bin. Releasing the older key (code ≠ bin) leaves bin unchanged.
- Latency: key_valid asserts SYNC_STAGES+3 clk after the stop-bit falling edge on the pin.
- Reset mid-frame: the partial frame is lost. Pending brk/ext flags are cleared.

Optional Feature:
- PS2_PARITY_CHECK_EN
  - Defined: in DONE, odd parity over the 8 data bits plus the parity bit is checked. A mismatch pulses frame_err and the byte is not decoded; brk/ext are unchanged.
  - Undefined: the parity bit is shifted in and ignored; no parity logic is synthesised.

Decomposition:
- Package kbd_pkg:
  - code constants CODE_NONE=0, CODE_RED=10, CODE_GREEN=11, CODE_BLUE=12;
  - scancode constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_KEY1..SC_KEY9, SC_R, SC_G, SC_B;
  - frame FSM state encoding.
- Sub-module ps2_rx_frame:
  - contains the synchronizers, edge detect, shift register, bit counter, watchdog, and the parity check when enabled;
  - outputs byte[7:0], byte_valid pulse and err pulse.
- The top level holds the brk/ext flags and the code mapping.

Test Plan:
- Send frame 0x16 (valid parity, 12.5 kHz ps2_clk) → bin=1, key_valid one pulse SYNC_STAGES+3 clk after the stop edge.
- Send 0x34, then F0 34 → bin=11 after the first byte; bin=0 after the break, with no key_valid on the F0 or the break byte.
- Send 0x1E, 0x26, then F0 1E → bin 2 → 3, and stays 3 after the release of key 2.
- Send E0 16 and unmapped 0x1C with bin=5 → bin stays 5, no key_valid, ext flag cleared after 0x16.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES → frame_err one pulse; a following frame 0x2D gives bin=10.
- With PS2_PARITY_CHECK_EN, send 0x32 with a flipped parity bit → frame_err pulse and bin unchanged; without the macro the same frame gives bin=12.
- Assert rst_n low mid-frame after 3 bits → all outputs 0; the next full frame 0x46 gives bin=9.
